// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the two-client multiplier arbiter.
package mult_arb_pkg;

    localparam int W_DEF       = 8;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        LOAD_HI,
        LOAD_LO,
        WAIT,
        DONE,
        ABORT
    } state_t;

    typedef logic [1:0] half_idx_t;

endpackage

// File: rtl/mult_arb_timer.sv
// WAIT-state cycle counter; expired flags the last permitted cycle (TIMEOUT-1).
module mult_arb_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    assign expired = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter feeding two clients' operands to a shared serial multiplier.
//   state   | meaning
//   IDLE    | waiting for req0/req1, winner latched on exit
//   GRANT   | one-cycle m_start strobe
//   LOAD_HI | m_get high, current half on m_data
//   LOAD_LO | m_get low, half held; advance index
//   WAIT    | waiting for m_ready, bounded by timer
//   DONE    | done pulse for granted client
//   ABORT   | err pulse after timeout
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic           req1,
    input  logic [W-1:0]   a0,
    input  logic [W-1:0]   b0,
    input  logic [W-1:0]   a1,
    input  logic [W-1:0]   b1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           done0,
    output logic           done1,
    output logic           err,
    output logic [2*W-1:0] prod_out,
    output logic           m_start,
    output logic           m_get,
    output logic [W/2-1:0] m_data,
    input  logic           m_ready,
    input  logic [2*W-1:0] m_prod
);

    localparam int H = W / 2;

    state_t         state, state_d;
    half_idx_t      idx;
    logic           client;
    logic           last;
    logic [W-1:0]   op_a, op_b;
    logic [H-1:0]   half_cur;
    logic           winner;
    logic           any_req;
    logic           expired;

    mult_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != WAIT),
        .enable  (state == WAIT),
        .expired (expired)
    );

    // Tie goes to the client that was not served last.
    always_comb begin
        any_req = req0 | req1;
        winner  = (req0 && req1) ? ~last : req1;
    end

    always_comb begin
        half_cur = '0;
        case (idx)
            2'd0: half_cur = op_a[H-1:0];
            2'd1: half_cur = op_a[W-1:H];
            2'd2: half_cur = op_b[H-1:0];
            2'd3: half_cur = op_b[W-1:H];
            default: half_cur = '0;
        endcase
    end

    always_comb begin
        state_d = state;
        m_start = 1'b0;
        m_get   = 1'b0;
        m_data  = '0;
        done0   = 1'b0;
        done1   = 1'b0;
        err     = 1'b0;
        case (state)
            IDLE:    if (any_req) state_d = GRANT;
            GRANT: begin
                m_start = 1'b1;
                state_d = LOAD_HI;
            end
            LOAD_HI: begin
                m_get   = 1'b1;
                m_data  = half_cur;
                state_d = LOAD_LO;
            end
            LOAD_LO: begin
                m_data  = half_cur;
                state_d = (idx == 2'd3) ? WAIT : LOAD_HI;
            end
            // success has priority over a simultaneous timeout
            WAIT: begin
                if (m_ready)      state_d = DONE;
                else if (expired) state_d = ABORT;
            end
            DONE: begin
                done0   = ~client;
                done1   = client;
                state_d = IDLE;
            end
            ABORT: begin
                err     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            client   <= 1'b0;
            last     <= 1'b1;
            op_a     <= '0;
            op_b     <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            prod_out <= '0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        client <= winner;
                        op_a   <= winner ? a1 : a0;
                        op_b   <= winner ? b1 : b0;
                        gnt0   <= ~winner;
                        gnt1   <= winner;
                        idx    <= '0;
                    end
                end
                LOAD_LO: idx <= idx + 2'd1;
                WAIT:    if (m_ready) prod_out <= m_prod;
                DONE, ABORT: begin
                    last <= client;
                    gnt0 <= 1'b0;
                    gnt1 <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench for mult_arbiter with a small serial multiplier model.
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [7:0]  a0, b0, a1, b1;
    logic        gnt0, gnt1, done0, done1, err;
    logic [15:0] prod_out;
    logic        m_start, m_get;
    logic [3:0]  m_data;
    logic        m_ready;
    logic [15:0] m_prod;

    int checks   = 0;
    int failures = 0;

    mult_arbiter #(.W(8), .TIMEOUT(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .a0       (a0),
        .b0       (b0),
        .a1       (a1),
        .b1       (b1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done0    (done0),
        .done1    (done1),
        .err      (err),
        .prod_out (prod_out),
        .m_start  (m_start),
        .m_get    (m_get),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .m_prod   (m_prod)
    );

    always #5 clk = ~clk;

    // Multiplier model: collects four halves on m_get, multiplies b*a.
    logic [3:0] hq [4];
    int         hk = 0;
    logic [3:0] mdq [$];
    logic       gq [$];
    int         done0_cnt = 0, done1_cnt = 0, err_cnt = 0;
    logic       gnt_both = 1'b0, done_both = 1'b0;

    always_comb m_prod = 16'({hq[3], hq[2]}) * 16'({hq[1], hq[0]});

    initial begin
        for (int i = 0; i < 4; i++) hq[i] = 4'h0;
    end

    always @(posedge clk) begin
        if (m_start) begin
            hk <= 0;
            gq.push_back(gnt1);
        end else if (m_get && hk < 4) begin
            hq[hk] <= m_data;
            hk     <= hk + 1;
        end
        if (m_get) mdq.push_back(m_data);
        if (done0) done0_cnt <= done0_cnt + 1;
        if (done1) done1_cnt <= done1_cnt + 1;
        if (err)   err_cnt   <= err_cnt + 1;
        if (gnt0 && gnt1)   gnt_both  <= 1'b1;
        if (done0 && done1) done_both <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_evt(input int budget, output int cycles);
        cycles = 0;
        while (!(done0 || done1 || err) && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},  {30'd0, gnt1, gnt0}, 32'd0);
        check({tag, "_done"}, {29'd0, err, done1, done0}, 32'd0);
        check({tag, "_mctl"}, {26'd0, m_start, m_get, m_data}, 32'd0);
        check({tag, "_prod"}, {16'd0, prod_out}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int e0, d0, d1;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; m_ready = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Single op: 0x0F * 0x03, m_ready after five idle WAIT cycles
        a0 = 8'h0F; b0 = 8'h03; req0 = 1'b1;
        tick();
        check("t1_grant", {30'd0, m_start, gnt0}, 32'd3);
        check("t1_gnt1", {31'd0, gnt1}, 32'd0);
        req0 = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 1) check("t1_start_once", {30'd0, m_start, m_get}, 32'd1);
            if (i == 9) check("t1_wait_mdata", {27'd0, m_get, m_data}, 32'd0);
            if (i == 14) m_ready = 1'b1;
            check("t1_no_early_done", {31'd0, done0}, 32'd0);
        end
        tick();
        m_ready = 1'b0;
        check("t1_done0", {29'd0, gnt0, done1, done0}, 32'h5);
        check("t1_prod", {16'd0, prod_out}, 32'h002D);
        tick();
        check("t1_after", {30'd0, gnt0, done0}, 32'd0);
        check("t1_nhalves", mdq.size(), 32'd4);
        if (mdq.size() >= 4) begin
            check("t1_half0", {28'd0, mdq[0]}, 32'hF);
            check("t1_half1", {28'd0, mdq[1]}, 32'h0);
            check("t1_half2", {28'd0, mdq[2]}, 32'h3);
            check("t1_half3", {28'd0, mdq[3]}, 32'h0);
        end

        // Round-robin after reset with both clients always requesting
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gq.delete();
        a0 = 8'h03; b0 = 8'h05; a1 = 8'h07; b1 = 8'h06;
        m_ready = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_evt(40, cyc);
            check("rr_latency", cyc, 32'd11);
            check("rr_client", {30'd0, done1, done0}, (k % 2 == 0) ? 32'd1 : 32'd2);
            check("rr_prod", {16'd0, prod_out}, (k % 2 == 0) ? 32'h000F : 32'h002A);
            if (k == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            tick();
        end
        check("rr_order_n", gq.size(), 32'd4);
        if (gq.size() >= 4)
            check("rr_order", {28'd0, gq[3], gq[2], gq[1], gq[0]}, 32'b1010);

        // Timeout: m_ready never comes
        m_ready = 1'b0;
        tick();
        e0 = err_cnt; d1 = done1_cnt;
        a1 = 8'h55; b1 = 8'h02; req1 = 1'b1;
        tick();
        check("to_grant", {30'd0, gnt1, m_start}, 32'd3);
        req1 = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        for (int i = 0; i < 63; i++) tick();
        check("to_err_not_yet", {31'd0, err}, 32'd0);
        tick();
        check("to_err", {30'd0, err, done1}, 32'd2);
        check("to_prod_kept", {16'd0, prod_out}, 32'h002A);
        tick();
        check("to_after", {29'd0, err, gnt1, gnt0}, 32'd0);
        check("to_err_count", err_cnt - e0, 32'd1);
        check("to_no_done", done1_cnt - d1, 32'd0);

        a0 = 8'hFF; b0 = 8'hFF; req0 = 1'b1; m_ready = 1'b1;
        tick();
        req0 = 1'b0;
        wait_evt(30, cyc);
        check("to_next_done", {30'd0, done1, done0}, 32'd1);
        check("to_next_prod", {16'd0, prod_out}, 32'hFE01);
        tick();

        // Reset during the third LOAD_HI
        m_ready = 1'b0;
        a0 = 8'h21; b0 = 8'h43; req0 = 1'b1;
        tick();
        req0 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("rs_third_load", {27'd0, m_get, m_data}, 32'h13);
        d0 = done0_cnt; e0 = err_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("rs_mid");
        for (int i = 0; i < 20; i++) tick();
        check("rs_silent", (done0_cnt - d0) + (err_cnt - e0), 32'd0);
        a1 = 8'h80; b1 = 8'h02; req1 = 1'b1; m_ready = 1'b1;
        tick();
        req1 = 1'b0;
        wait_evt(30, cyc);
        check("rs_fresh_done", {30'd0, done1, done0}, 32'd2);
        check("rs_fresh_prod", {16'd0, prod_out}, 32'h0100);
        tick();

        // req1 dropped during WAIT, m_ready arrives later
        m_ready = 1'b0;
        a1 = 8'h0A; b1 = 8'h0B; req1 = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) tick();
        req1 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("dw_still_gnt", {30'd0, gnt1, done1}, 32'd2);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("dw_done1", {30'd0, done1, done0}, 32'd2);
        check("dw_prod", {16'd0, prod_out}, 32'h006E);
        tick();

        check("no_gnt_overlap", {31'd0, gnt_both}, 32'd0);
        check("no_done_overlap", {31'd0, done_both}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
